// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit owning the HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional macro MDU_DIV_ZERO_DETECT_EN: divide by zero finishes at once with a div_zero pulse, HI/LO kept.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             op_div, neg_q, neg_r;

    logic             accept, last, zero_skip, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign accept    = (state == IDLE) && start;
    assign last      = (state == RUN) && (count == CNT_W'(WIDTH - 1));
    assign busy      = (state == RUN);
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

`ifdef MDU_DIV_ZERO_DETECT_EN
    assign zero_skip = accept && op[1] && (b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // acc_hi holds the partial product / partial remainder, acc_lo the multiplier / dividend-quotient.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    always_comb begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (op_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign prod     = {step_hi, step_lo};
    assign prod_neg = -prod;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !zero_skip) state_next = RUN;
            RUN:  if (last)                 state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDU_DIV_ZERO_DETECT_EN
            div_zero <= 1'b0;
`endif
            if (accept) begin
                // start wins over a same-cycle MTHI/MTLO
                if (zero_skip) begin
                    done <= 1'b1;
`ifdef MDU_DIV_ZERO_DETECT_EN
                    div_zero <= 1'b1;
`endif
                end else begin
                    count  <= '0;
                    acc_hi <= '0;
                    acc_lo <= a_mag;
                    opnd   <= b_mag;
                    op_div <= op[1];
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                end
            end else if (state == IDLE) begin
                if (hi_write) hi <= wr_data;
                if (lo_write) lo <= wr_data;
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    if (op_div) begin
                        lo <= neg_q ? -step_lo : step_lo;
                        hi <= neg_r ? -step_hi : step_hi;
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : prod;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: constant vector table, hand sequences for busy/reset/zero-divide corners,
// and randomized operations checked against an arithmetic model of HI/LO.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b, wr_data;
    logic        hi_write, lo_write;
    logic        busy, done;
    logic [31:0] hi, lo;
`ifdef MDU_DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_hi, model_lo;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_write(hi_write), .lo_write(lo_write), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV_ZERO_DETECT_EN
        , .div_zero(div_zero)
`endif
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit / signed arithmetic; returns zs=1 when the zero-divide shortcut applies.
    task automatic model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                         output logic [31:0] rh, output logic [31:0] rl, output logic zs);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb;
        sa = ma; sb = mb; zs = 1'b0;
        rh = model_hi; rl = model_lo;
        case (mop)
            2'd0: begin sp = $signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb}); {rh, rl} = sp; end
            2'd1: begin up = {32'd0, ma} * {32'd0, mb}; {rh, rl} = up; end
            default: begin
`ifdef MDU_DIV_ZERO_DETECT_EN
                if (mb == 0) zs = 1'b1;
`endif
                if (zs) begin
                    rh = model_hi; rl = model_lo;
                end else if (mb == 0) begin
                    rh = ma;
                    rl = (mop == 2'd2 && ma[31]) ? 32'd1 : 32'hFFFF_FFFF;
                end else if (mop == 2'd3) begin
                    rl = ma / mb; rh = ma % mb;
                end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 32'd0;
                end else begin
                    rl = sa / sb; rh = sa % sb;
                end
            end
        endcase
    endtask

    task automatic wait_done(inout int n);
        while (!done && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    // Starts an operation now, waits for done, checks latency and results.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic zs);
        int n;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        check({name, " busy"}, {31'd0, busy}, {31'd0, !zs});
        n = 0;
        wait_done(n);
        check({name, " latency"}, n, zs ? 0 : 32);
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        check({name, " busy_end"}, {31'd0, busy}, 32'd0);
`ifdef MDU_DIV_ZERO_DETECT_EN
        check({name, " div_zero"}, {31'd0, div_zero}, {31'd0, zs});
`endif
        model_hi = eh; model_lo = el;
    endtask

    vec_t vecs[6];

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic [1:0]  ro;
        logic        zs;
        int          n;

        vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{2'd0, 32'd0,         32'h0001_2345, 32'd0,         32'd0};

        reset = 1'b1; start = 1'b0; op = 2'd0; a = 0; b = 0;
        hi_write = 1'b0; lo_write = 1'b0; wr_data = 0;
        model_hi = 0; model_lo = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
`ifdef MDU_DIV_ZERO_DETECT_EN
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
`endif

        // Table vectors, issued back to back while done is still high.
        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                                 vecs[i].exp_hi, vecs[i].exp_lo, 1'b0);
        @(posedge clock); #1;
        check("done one cycle", {31'd0, done}, 32'd0);

        // Start together with MTHI: start wins.
        hi_write = 1'b1; wr_data = 32'h5555;
        run_op("start_vs_mthi", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        hi_write = 1'b0;
        @(posedge clock); #1;

        // MTHI and a second start during RUN are ignored.
        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; n = 0;
        repeat (5) begin @(posedge clock); #1; n++; end
        hi_write = 1'b1; lo_write = 1'b1; wr_data = 32'h1234; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
        @(posedge clock); #1; n++;
        hi_write = 1'b0; lo_write = 1'b0; start = 1'b0;
        wait_done(n);
        check("busy_ign latency", n, 32);
        check("busy_ign hi", hi, 32'd2);
        check("busy_ign lo", lo, 32'd14);
        @(posedge clock); #1;
        check("busy_ign no restart", {31'd0, busy}, 32'd0);

        // MTLO / MTHI in IDLE.
        lo_write = 1'b1; wr_data = 32'hABCD;
        @(posedge clock); #1;
        lo_write = 1'b0;
        check("mtlo lo", lo, 32'hABCD);
        check("mtlo hi kept", hi, 32'd2);
        hi_write = 1'b1; wr_data = 32'h7777_0001;
        @(posedge clock); #1;
        hi_write = 1'b0;
        check("mthi hi", hi, 32'h7777_0001);
        model_hi = 32'h7777_0001; model_lo = 32'hABCD;

        // Divide by zero.
        model(2'd3, 32'd5, 32'd0, rh, rl, zs);
`ifdef MDU_DIV_ZERO_DETECT_EN
        run_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'h7777_0001, 32'hABCD, 1'b1);
        @(posedge clock); #1;
        check("div_zero one cycle", {31'd0, div_zero}, 32'd0);
        run_op("div_by0", 2'd2, 32'hFFFF_FFF8, 32'd0, 32'h7777_0001, 32'hABCD, 1'b1);
`else
        run_op("divu_by0", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0", 2'd2, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'd1, 1'b0);
`endif
        check("model divu_by0 hi", rh, zs ? 32'h7777_0001 : 32'd5);

        // Reset mid-operation aborts and clears HI/LO.
        @(posedge clock); #1;
        op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        model_hi = 0; model_lo = 0;
        run_op("after_abort", 2'd3, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 3));
                1: rb = -32'($urandom_range(1, 4));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, rh, rl, zs);
            run_op($sformatf("rnd%0d op%0d", i, ro), ro, ra, rb, rh, rl, zs);
            if ($urandom_range(0, 1) == 1) begin @(posedge clock); #1; end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
